// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch lookup and execute redirect are combinational; table and stats update on the clock edge.
module branch_predictor_btb #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int INDEX_BITS        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_F,
    output logic                         Predicted,
    output logic [WIDTH_DATA_LENGTH-1:0] PC_Pre,
    input  logic                         Update,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_E,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
    input  logic                         Execute,
    input  logic [1:0]                   Result,
    output logic                         Redirect,
    output logic [WIDTH_DATA_LENGTH-1:0] PC_Redirect,
    output logic [WIDTH_DATA_LENGTH-1:0] Branch_Count,
    output logic [WIDTH_DATA_LENGTH-1:0] Mispredict_Count
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = WIDTH_DATA_LENGTH - INDEX_BITS - 2;

    localparam logic [1:0] RES_WRONG_TARGET = 2'b00;
    localparam logic [1:0] RES_CORRECT      = 2'b01;
    localparam logic [1:0] RES_FALSE_TAKEN  = 2'b10;
    localparam logic [1:0] RES_MISSED_TAKEN = 2'b11;

    logic                         entry_valid  [ENTRIES];
    logic [TAG_BITS-1:0]          entry_tag    [ENTRIES];
    logic [WIDTH_DATA_LENGTH-1:0] entry_target [ENTRIES];
    logic [1:0]                   entry_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] f_index;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;
    logic [INDEX_BITS-1:0] e_index;
    logic [TAG_BITS-1:0]   e_tag;
    logic                  e_hit;

    assign f_index = PC_F[INDEX_BITS+1:2];
    assign f_tag   = PC_F[WIDTH_DATA_LENGTH-1:INDEX_BITS+2];
    assign e_index = PC_E[INDEX_BITS+1:2];
    assign e_tag   = PC_E[WIDTH_DATA_LENGTH-1:INDEX_BITS+2];

    // Lookups read registered state only, so a same-cycle write is not visible.
    assign f_hit = entry_valid[f_index] && (entry_tag[f_index] == f_tag);
    assign e_hit = entry_valid[e_index] && (entry_tag[e_index] == e_tag);

    assign Predicted = f_hit && entry_ctr[f_index][1];
    assign PC_Pre    = Predicted ? entry_target[f_index]
                                 : PC_F + WIDTH_DATA_LENGTH'(4);

    // Update is a single-cycle valid strobe with no back-pressure: when high,
    // PC_E/PC_ALU/Execute/Result describe one resolved branch, consumed at this edge.
    always_comb begin
        Redirect    = 1'b0;
        PC_Redirect = '0;
        if (Update) begin
            case (Result)
                RES_WRONG_TARGET,
                RES_MISSED_TAKEN: begin
                    Redirect    = 1'b1;
                    PC_Redirect = PC_ALU;
                end
                RES_FALSE_TAKEN: begin
                    Redirect    = 1'b1;
                    PC_Redirect = PC_E + WIDTH_DATA_LENGTH'(4);
                end
                default: begin
                    Redirect    = 1'b0;
                    PC_Redirect = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i]  <= 1'b0;
                entry_tag[i]    <= '0;
                entry_target[i] <= '0;
                entry_ctr[i]    <= 2'b01;
            end
        end else if (Update) begin
            if (e_hit) begin
                if (Execute) begin
                    if (entry_ctr[e_index] != 2'b11)
                        entry_ctr[e_index] <= entry_ctr[e_index] + 2'd1;
                    entry_target[e_index] <= PC_ALU;
                end else if (entry_ctr[e_index] != 2'b00) begin
                    entry_ctr[e_index] <= entry_ctr[e_index] - 2'd1;
                end
            end else if (Execute) begin
                // Direct-mapped: a taken miss evicts whatever lives at this index.
                entry_valid[e_index]  <= 1'b1;
                entry_tag[e_index]    <= e_tag;
                entry_target[e_index] <= PC_ALU;
                entry_ctr[e_index]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Branch_Count     <= '0;
            Mispredict_Count <= '0;
        end else if (Update) begin
            Branch_Count <= Branch_Count + WIDTH_DATA_LENGTH'(1);
            if (Result != RES_CORRECT)
                Mispredict_Count <= Mispredict_Count + WIDTH_DATA_LENGTH'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: a driver pushes hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor_btb;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] pc_f;
    logic         predicted;
    logic [W-1:0] pc_pre;
    logic         update;
    logic [W-1:0] pc_e;
    logic [W-1:0] pc_alu;
    logic         execute;
    logic [1:0]   result;
    logic         redirect;
    logic [W-1:0] pc_redirect;
    logic [W-1:0] branch_count;
    logic [W-1:0] mispredict_count;

    branch_predictor_btb #(.WIDTH_DATA_LENGTH(W), .INDEX_BITS(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .PC_F             (pc_f),
        .Predicted        (predicted),
        .PC_Pre           (pc_pre),
        .Update           (update),
        .PC_E             (pc_e),
        .PC_ALU           (pc_alu),
        .Execute          (execute),
        .Result           (result),
        .Redirect         (redirect),
        .PC_Redirect      (pc_redirect),
        .Branch_Count     (branch_count),
        .Mispredict_Count (mispredict_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           kind_q[$];
    int           vec_q[$];
    int           checks = 0;
    int           errors = 0;
    int           vec_no = 0;

    function automatic string kind_name(input int k);
        case (k)
            0:       return "Predicted";
            1:       return "PC_Pre";
            2:       return "Redirect";
            3:       return "PC_Redirect";
            4:       return "Branch_Count";
            default: return "Mispredict_Count";
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            int           k;
            int           v;
            exp_v = exp_q.pop_front();
            k     = kind_q.pop_front();
            v     = vec_q.pop_front();
            case (k)
                0:       act_v = W'(predicted);
                1:       act_v = pc_pre;
                2:       act_v = W'(redirect);
                3:       act_v = pc_redirect;
                4:       act_v = branch_count;
                default: act_v = mispredict_count;
            endcase
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h",
                         v, kind_name(k), act_v, exp_v);
            end
        end
    end

    // driver: apply one cycle of inputs just after the edge and queue the expected outputs
    task automatic vec(input logic r, input logic [W-1:0] f, input logic u,
                       input logic [W-1:0] e, input logic [W-1:0] alu,
                       input logic x, input logic [1:0] res,
                       input logic e_pred, input logic [W-1:0] e_pre,
                       input logic e_redir, input logic [W-1:0] e_pcr,
                       input logic [W-1:0] e_bc, input logic [W-1:0] e_mc);
        @(posedge clk);
        #1;
        rst     = r;
        pc_f    = f;
        update  = u;
        pc_e    = e;
        pc_alu  = alu;
        execute = x;
        result  = res;
        vec_no++;
        exp_q.push_back(W'(e_pred)); kind_q.push_back(0); vec_q.push_back(vec_no);
        exp_q.push_back(e_pre);      kind_q.push_back(1); vec_q.push_back(vec_no);
        exp_q.push_back(W'(e_redir));kind_q.push_back(2); vec_q.push_back(vec_no);
        exp_q.push_back(e_pcr);      kind_q.push_back(3); vec_q.push_back(vec_no);
        exp_q.push_back(e_bc);       kind_q.push_back(4); vec_q.push_back(vec_no);
        exp_q.push_back(e_mc);       kind_q.push_back(5); vec_q.push_back(vec_no);
    endtask

    initial begin
        rst = 1'b1; pc_f = '0; update = 1'b0; pc_e = '0; pc_alu = '0;
        execute = 1'b0; result = 2'b01;
        repeat (2) @(posedge clk);

        //   rst f            upd pc_e         alu          x   res    pred pre          rd  pcr          bc  mc
        vec(0, 32'h100,      0, 32'h0,        32'h0,       0, 2'b01, 0, 32'h104,      0, 32'h0,      0,  0);
        vec(0, 32'h100,      1, 32'h100,      32'h200,     1, 2'b11, 0, 32'h104,      1, 32'h200,    0,  0);
        vec(0, 32'h100,      1, 32'h100,      32'h200,     1, 2'b01, 1, 32'h200,      0, 32'h0,      1,  1);
        vec(0, 32'h100,      1, 32'h100,      32'h200,     1, 2'b01, 1, 32'h200,      0, 32'h0,      2,  1);
        vec(0, 32'h100,      1, 32'h100,      32'h999,     0, 2'b10, 1, 32'h200,      1, 32'h104,    3,  1);
        vec(0, 32'h100,      0, 32'h0,        32'h0,       0, 2'b01, 1, 32'h200,      0, 32'h0,      4,  2);
        vec(0, 32'h100,      1, 32'h100,      32'h999,     0, 2'b10, 1, 32'h200,      1, 32'h104,    4,  2);
        vec(0, 32'h100,      0, 32'h0,        32'h0,       0, 2'b01, 0, 32'h104,      0, 32'h0,      5,  3);
        vec(0, 32'h100,      1, 32'h100,      32'h0,       0, 2'b01, 0, 32'h104,      0, 32'h0,      5,  3);
        vec(0, 32'h100,      1, 32'h100,      32'h0,       0, 2'b01, 0, 32'h104,      0, 32'h0,      6,  3);
        vec(0, 32'h100,      1, 32'h100,      32'h200,     1, 2'b11, 0, 32'h104,      1, 32'h200,    7,  3);
        vec(0, 32'h100,      1, 32'h100,      32'h200,     1, 2'b11, 0, 32'h104,      1, 32'h200,    8,  4);
        vec(0, 32'h100,      0, 32'h0,        32'h0,       0, 2'b01, 1, 32'h200,      0, 32'h0,      9,  5);
        // target change
        vec(0, 32'h100,      1, 32'h100,      32'h300,     1, 2'b00, 1, 32'h200,      1, 32'h300,    9,  5);
        vec(0, 32'h100,      0, 32'h0,        32'h0,       0, 2'b01, 1, 32'h300,      0, 32'h0,      10, 6);
        // aliasing: 0x140 shares index 0 with 0x100
        vec(0, 32'h140,      1, 32'h140,      32'h500,     1, 2'b11, 0, 32'h144,      1, 32'h500,    10, 6);
        vec(0, 32'h100,      0, 32'h0,        32'h0,       0, 2'b01, 0, 32'h104,      0, 32'h0,      11, 7);
        vec(0, 32'h140,      0, 32'h0,        32'h0,       0, 2'b01, 1, 32'h500,      0, 32'h0,      11, 7);
        // not-taken miss must not allocate
        vec(0, 32'h140,      1, 32'h240,      32'h0,       0, 2'b01, 1, 32'h500,      0, 32'h0,      11, 7);
        vec(0, 32'h140,      0, 32'h0,        32'h0,       0, 2'b01, 1, 32'h500,      0, 32'h0,      12, 7);
        // same-cycle lookup of the entry being written sees old contents
        vec(0, 32'h108,      1, 32'h108,      32'h800,     1, 2'b11, 0, 32'h10C,      1, 32'h800,    12, 7);
        vec(0, 32'h108,      0, 32'h0,        32'h0,       0, 2'b01, 1, 32'h800,      0, 32'h0,      13, 8);
        vec(0, 32'hFFFFFFFC, 0, 32'h0,        32'h0,       0, 2'b01, 0, 32'h0,        0, 32'h0,      13, 8);
        // Result ignored without Update
        vec(0, 32'h108,      0, 32'h108,      32'h900,     1, 2'b00, 1, 32'h800,      0, 32'h0,      13, 8);
        // reset beats a concurrent update
        vec(1, 32'h108,      1, 32'h108,      32'hA00,     1, 2'b11, 1, 32'h800,      1, 32'hA00,    13, 8);
        vec(0, 32'h108,      0, 32'h0,        32'h0,       0, 2'b01, 0, 32'h10C,      0, 32'h0,      0,  0);
        vec(0, 32'h140,      1, 32'h140,      32'h0,       0, 2'b10, 0, 32'h144,      1, 32'h144,    0,  0);
        vec(0, 32'h140,      0, 32'h0,        32'h0,       0, 2'b01, 0, 32'h144,      0, 32'h0,      1,  1);

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Fetch side: looks up the fetch PC combinationally and produces Predicted and PC_Pre for the branch-result stage.
- Execute side: consumes the resolved branch outcome and the 2-bit Result code, updates the table and counters on the next clock edge, and drives the fetch redirect.
- Also keeps resolved-branch and mispredict statistics counters.

Parameters:
- WIDTH_DATA_LENGTH, 32, width of PCs and statistics counters.
- INDEX_BITS, 4, log2 of entry count (16 entries); index = PC[INDEX_BITS+1:2].

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- PC_F  input  WIDTH_DATA_LENGTH  fetch-stage PC to look up.
- Predicted  output  1  prediction for PC_F, 1 = taken.
- PC_Pre  output  WIDTH_DATA_LENGTH  predicted target for PC_F; equals PC_F+4 when Predicted=0.
- Update  input  1  a branch/jump resolved in execute this cycle.
- PC_E  input  WIDTH_DATA_LENGTH  PC of the resolving branch.
- PC_ALU  input  WIDTH_DATA_LENGTH  actual target computed by the ALU.
- Execute  input  1  actual outcome, 1 = taken.
- Result  input  2  outcome code: 00 wrong target, 01 correct, 10 predicted taken but not taken, 11 not predicted but taken.
- Redirect  output  1  flush fetch and load PC_Redirect.
- PC_Redirect  output  WIDTH_DATA_LENGTH  corrected fetch PC.
- Branch_Count  output  WIDTH_DATA_LENGTH  number of accepted updates.
- Mispredict_Count  output  WIDTH_DATA_LENGTH  number of updates with Result != 01.

Behaviour:
- Entry contents: valid bit, tag = PC[WIDTH_DATA_LENGTH-1:INDEX_BITS+2], target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup is combinational from the register state:
  - hit = valid & (tag == PC_F tag).
  - Predicted = hit & counter[1].
  - PC_Pre = Predicted ? target : PC_F+4 (wraps modulo 2^WIDTH).
- Updates are applied at the posedge where Update=1. No latency beyond one edge; a same-cycle lookup of the entry being written returns the old contents.
- On a hit at PC_E:
  - Counter increments, saturating at 11, if Execute=1; otherwise it decrements, saturating at 00.
  - If Execute=1, target <= PC_ALU.
  - If Execute=0, target is unchanged.
- On a miss at PC_E:
  - If Execute=1, allocate and overwrite any occupant: valid=1, tag from PC_E, target=PC_ALU, counter=10.
  - If Execute=0, no change.
- Redirect and PC_Redirect are combinational and qualified by Update:
  - Result 00 or 11: Redirect=1, PC_Redirect=PC_ALU.
  - Result 10: Redirect=1, PC_Redirect=PC_E+4.
  - Result 01, or Update=0: Redirect=0, PC_Redirect=0.
- Statistics:
  - Branch_Count increments on every Update.
  - Mispredict_Count increments when Update=1 and Result != 01.
  - Both wrap from all-ones to 0.
- Reset: on any posedge with rst=1, all valid bits go to 0, all counters to 01, targets and tags to 0, and both statistics counters to 0.
  - Reset overrides a concurrent Update; the update is dropped.
  - Outputs after reset: Predicted=0, PC_Pre=PC_F+4. Redirect still follows Update/Result combinationally.
- Aliasing: two PCs with the same index and different tags evict each other. No associativity.
- Update with Execute=1 and Result=01 (correct taken prediction) still refreshes target and strengthens the counter.
- X or 2-state: Result is only meaningful when Update=1; it is ignored otherwise.

Test Plan:
- Reset, then PC_F=0x100 -> Predicted=0, PC_Pre=0x104; both counters read 0.
- Update PC_E=0x100, Execute=1, PC_ALU=0x200, Result=11 -> same cycle Redirect=1, PC_Redirect=0x200. Next cycle PC_F=0x100 gives Predicted=1, PC_Pre=0x200; Mispredict_Count=1, Branch_Count=1.
- Counter saturation on PC_E=0x100:
  - Two further taken updates (Result=01) -> counter 11.
  - Then one not-taken update with Result=10 -> Redirect=1, PC_Redirect=0x104, and Predicted stays 1 (counter 10).
  - A second not-taken update -> Predicted=0.
  - Further not-taken updates keep the counter at 00.
- Target change: the entry is predicted taken to 0x200, then an update with Execute=1, PC_ALU=0x300, Result=00 -> Redirect=1, PC_Redirect=0x300. Next lookup gives PC_Pre=0x300.
- Aliasing: allocate 0x100 taken, then update 0x140 (same index for INDEX_BITS=4) taken to 0x500 -> PC_F=0x100 gives Predicted=0, and PC_F=0x140 gives PC_Pre=0x500.
- Reset priority and same-cycle read:
  - rst=1 and Update=1 asserted together -> table empty and counts 0 afterwards.
  - A lookup during the write cycle of an entry returns the pre-update prediction.
